// File: rtl/uart_axis_rx.sv
// 8N1 UART receiver with an AXI4-Stream byte output and framing/overrun reporting.
// One bit period is prescale*8 clocks; prescale is latched at each start detection.
module uart_axis_rx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rxd,
   input  logic [15:0]           prescale,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic                  frame_error,
   output logic                  overrun_error
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                state, state_n;
   logic                  rxd_meta, rxd_s;
   logic [18:0]           cnt;
   logic [15:0]           p_reg;
   logic [2:0]            bit_idx;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  sample;
   logic                  load_half, load_full, shift_en, stop_good, stop_bad;
   logic                  handshake;

   assign sample    = (cnt == 19'd0);
   assign handshake = m_axis_tvalid && m_axis_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_s    <= rxd_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      load_half = 1'b0;
      load_full = 1'b0;
      shift_en  = 1'b0;
      stop_good = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (!rxd_s && prescale != 16'd0) begin
               load_half = 1'b1;
               state_n   = START;
            end
         end
         START: begin
            if (sample) begin
               if (rxd_s) begin
                  state_n = IDLE;
               end else begin
                  load_full = 1'b1;
                  state_n   = DATA;
               end
            end
         end
         DATA: begin
            if (sample) begin
               shift_en  = 1'b1;
               load_full = 1'b1;
               if (bit_idx == 3'(DATA_WIDTH - 1)) state_n = STOP;
            end
         end
         STOP: begin
            if (sample) begin
               state_n   = IDLE;
               stop_good = rxd_s;
               stop_bad  = !rxd_s;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Bit timing: half a bit to the start-bit centre, then whole bits between samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         p_reg   <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         if (load_half) begin
            p_reg   <= prescale;
            cnt     <= {1'b0, prescale, 2'b00} - 19'd1;
            bit_idx <= '0;
         end else if (load_full) begin
            cnt <= {p_reg, 3'b000} - 19'd1;
         end else if (cnt != 19'd0) begin
            cnt <= cnt - 19'd1;
         end
         if (shift_en) begin
            shreg   <= {rxd_s, shreg[DATA_WIDTH-1:1]};
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   // A completed byte may replace the held one only if the slot is free or draining now.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         busy          <= 1'b0;
         frame_error   <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         busy          <= (state_n != IDLE);
         frame_error   <= stop_bad;
         overrun_error <= stop_good && m_axis_tvalid && !m_axis_tready;
         if (stop_good && (!m_axis_tvalid || m_axis_tready)) begin
            m_axis_tdata  <= shreg;
            m_axis_tvalid <= 1'b1;
         end else if (handshake) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_axis_rx.sv
// Self-checking bench for uart_axis_rx: serial frames in, AXI-stream bytes and error pulses out,
// compared against an expected-byte queue and expected pulse counts.
module tb_uart_axis_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        rxd;
   logic [15:0] prescale;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        busy;
   logic        frame_error;
   logic        overrun_error;

   always #5 clk = ~clk;

   uart_axis_rx #(.DATA_WIDTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .rxd           (rxd),
      .prescale      (prescale),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .frame_error   (frame_error),
      .overrun_error (overrun_error)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Observer: records every handshake and counts pulses, busy and tvalid cycles.
   logic [7:0] got[$];
   int         fe_cnt    = 0;
   int         ov_cnt    = 0;
   int         busy_cyc  = 0;
   int         tv_cyc    = 0;
   int         hold_viol = 0;
   logic       hold_prev = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(negedge clk) begin
      if (hold_prev && (!m_axis_tvalid || m_axis_tdata !== prev_data)) hold_viol++;
      hold_prev = m_axis_tvalid && !m_axis_tready && !rst;
      prev_data = m_axis_tdata;
      if (m_axis_tvalid && m_axis_tready && !rst) got.push_back(m_axis_tdata);
      if (frame_error)   fe_cnt++;
      if (overrun_error) ov_cnt++;
      if (busy)          busy_cyc++;
      if (m_axis_tvalid) tv_cyc++;
   end

   // Reference model state: the bytes that must come out, in order.
   logic [7:0] exp_q[$];
   int         chk = 0;
   int         fe_base, ov_base, busy_base, tv_base;

   task automatic snapshot();
      fe_base   = fe_cnt;
      ov_base   = ov_cnt;
      busy_base = busy_cyc;
      tv_base   = tv_cyc;
   endtask

   task automatic compareStream(input string tag);
      checkOutput({tag, "_count"}, got.size(), exp_q.size());
      for (int i = chk; i < exp_q.size(); i++)
         if (i < got.size()) checkOutput({tag, "_byte"}, int'(got[i]), int'(exp_q[i]));
      chk = exp_q.size();
      checkOutput({tag, "_axi_hold"}, hold_viol, 0);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives the first nbits bit periods of an 8N1 frame at 8*p clocks per bit.
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int p,
                                input int nbits, input bit scramble);
      logic [9:0] frame;
      frame    = {stop_bit, b, 1'b0};
      prescale = 16'(p);
      for (int i = 0; i < nbits; i++) begin
         rxd = frame[i];
         repeat (8 * p) @(posedge clk);
         #1;
         if (i == 0 && scramble) prescale = 16'($urandom_range(0, 7));
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_tvalid"}, int'(m_axis_tvalid), 0);
      checkOutput({tag, "_tdata"},  int'(m_axis_tdata),  0);
      checkOutput({tag, "_busy"},   int'(busy),          0);
      checkOutput({tag, "_ferr"},   int'(frame_error),   0);
      checkOutput({tag, "_oerr"},   int'(overrun_error), 0);
   endtask

   initial begin
      int         p, gap, fe_exp;
      logic [7:0] b;
      bit         good;

      rst           = 1'b1;
      rxd           = 1'b1;
      prescale      = 16'd1;
      m_axis_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkResetOutputs("reset");
      idle(4);

      // Single byte at 8 clocks per bit.
      snapshot();
      applyStimulus(8'hA5, 1'b1, 1, 10, 1'b0);
      exp_q.push_back(8'hA5);
      idle(20);
      compareStream("single");
      checkOutput("single_busy_cycles",   busy_cyc - busy_base, 76);
      checkOutput("single_tvalid_cycles", tv_cyc - tv_base,     1);
      checkOutput("single_ferr",          fe_cnt - fe_base,     0);
      checkOutput("single_oerr",          ov_cnt - ov_base,     0);

      // Back-to-back frames with no idle gap.
      snapshot();
      applyStimulus(8'h00, 1'b1, 2, 10, 1'b0);
      applyStimulus(8'hFF, 1'b1, 2, 10, 1'b0);
      applyStimulus(8'h3C, 1'b1, 2, 10, 1'b0);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h3C);
      idle(30);
      compareStream("b2b");
      checkOutput("b2b_errors", (fe_cnt - fe_base) + (ov_cnt - ov_base), 0);

      // Backpressure: second byte overruns and is dropped.
      snapshot();
      m_axis_tready = 1'b0;
      applyStimulus(8'h3C, 1'b1, 1, 10, 1'b0);
      idle(4);
      applyStimulus(8'hC3, 1'b1, 1, 10, 1'b0);
      idle(20);
      @(negedge clk);
      checkOutput("ovr_tvalid_held", int'(m_axis_tvalid), 1);
      checkOutput("ovr_tdata_held",  int'(m_axis_tdata),  'h3C);
      checkOutput("ovr_pulses",      ov_cnt - ov_base,    1);
      checkOutput("ovr_ferr",        fe_cnt - fe_base,    0);
      @(posedge clk);
      #1;
      m_axis_tready = 1'b1;
      @(posedge clk);
      #1;
      m_axis_tready = 1'b0;
      @(negedge clk);
      checkOutput("ovr_tvalid_drop", int'(m_axis_tvalid), 0);
      exp_q.push_back(8'h3C);
      idle(10);
      compareStream("ovr");
      m_axis_tready = 1'b1;

      // Framing error, then a good byte.
      snapshot();
      applyStimulus(8'h55, 1'b0, 1, 10, 1'b0);
      idle(20);
      checkOutput("frm_pulses",      fe_cnt - fe_base, 1);
      checkOutput("frm_tvalid_none", tv_cyc - tv_base, 0);
      applyStimulus(8'h12, 1'b1, 1, 10, 1'b0);
      exp_q.push_back(8'h12);
      idle(20);
      compareStream("frm");

      // Glitch: short low pulse aborts at the start sample.
      snapshot();
      prescale = 16'd4;
      rxd      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      idle(60);
      checkOutput("glitch_busy_cycles", busy_cyc - busy_base, 16);
      checkOutput("glitch_busy_now",    int'(busy),           0);
      checkOutput("glitch_tvalid",      tv_cyc - tv_base,     0);
      checkOutput("glitch_errors",      (fe_cnt - fe_base) + (ov_cnt - ov_base), 0);

      // Randomized frames, random bit rates, occasional bad stop bits, prescale disturbed mid-frame.
      snapshot();
      fe_exp = 0;
      for (int k = 0; k < 12; k++) begin
         p    = $urandom_range(1, 3);
         b    = 8'($urandom);
         good = ($urandom_range(0, 4) != 0);
         applyStimulus(b, good, p, 10, 1'b1);
         if (good) begin
            exp_q.push_back(b);
            gap = $urandom_range(0, 6);
         end else begin
            fe_exp++;
            gap = 8 * p + 8;
         end
         idle(gap);
      end
      idle(40);
      compareStream("rand");
      checkOutput("rand_ferr", fe_cnt - fe_base, fe_exp);
      checkOutput("rand_oerr", ov_cnt - ov_base, 0);

      // Reset mid-frame discards the pending byte and the partial frame.
      m_axis_tready = 1'b0;
      applyStimulus(8'h11, 1'b1, 1, 10, 1'b0);
      idle(10);
      applyStimulus(8'h81, 1'b1, 1, 5, 1'b0);
      rxd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rxd = 1'b1;
      @(negedge clk);
      checkResetOutputs("midrst");
      idle(20);
      m_axis_tready = 1'b1;
      snapshot();
      applyStimulus(8'h7E, 1'b1, 1, 10, 1'b0);
      exp_q.push_back(8'h7E);
      idle(20);
      compareStream("midrst");
      checkOutput("midrst_errors", (fe_cnt - fe_base) + (ov_cnt - ov_base), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_axis_rx.md
# uart_axis_rx

UART receiver that deserializes an 8N1 asynchronous serial line into bytes on an AXI4-Stream master interface. It is the receive-side counterpart of the team's AXI-stream-fed UART transmitter and uses the same `prescale` convention: one bit period is `prescale*8` clock cycles. It sits between the board-level `rxd` pin and the byte consumer, such as a FIFO or command parser. It also reports framing and overrun errors.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame; only 8 is supported.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- rxd  input  1  asynchronous serial input; idle level is 1.
- prescale  input  16  bit period = prescale*8 clocks; sampled when a start edge is detected.
- m_axis_tdata  output  8  received byte.
- m_axis_tvalid  output  1  byte available.
- m_axis_tready  input  1  consumer accepts the byte.
- busy  output  1  frame reception in progress.
- frame_error  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun_error  output  1  one-cycle pulse: a byte completed while the previous byte was unaccepted.

## Operation
- **Synchronizer**: two flip-flops on `rxd`, reset to 1. All logic uses the synchronized value `rxd_s`.
- **State machine**: IDLE, START, DATA, STOP.
- **IDLE**: when `rxd_s==0` and `prescale!=0`:
  - latch `prescale` into P;
  - load the bit counter with 4P-1 (half a bit);
  - set bit_idx=0, assert `busy`, go to START.
  - When `prescale==0`, the block stays in IDLE.
- **Counter**: 19-bit down-counter, loaded with N-1. The sample event fires the cycle the counter reads 0, which is N cycles after the load.
- **START sample**:
  - `rxd_s==1` means a glitch: abort to IDLE, clear `busy`, produce no output and no error.
  - `rxd_s==0`: load 8P-1, go to DATA.
- **DATA sample**: shift `rxd_s` in LSB-first, as `shreg <= {rxd_s, shreg[7:1]}`, and load 8P-1. After the 8th bit, go to STOP.
- **STOP sample**: go to IDLE and clear `busy`.
  - `rxd_s==1`: the byte is good.
    - If `m_axis_tvalid==0`, or the current byte is being accepted this cycle (`tvalid && tready`), register `shreg` into `m_axis_tdata` and set `m_axis_tvalid`.
    - Otherwise, pulse `overrun_error` and drop the new byte. The held byte is unchanged.
  - `rxd_s==0`: pulse `frame_error` and drop the byte. `tvalid`/`tdata` are untouched.
- **AXI rules**:
  - `m_axis_tvalid` falls only on the cycle after `tvalid && tready`.
  - `m_axis_tdata` is stable while `tvalid` is high.
  - `tvalid` never depends combinationally on `tready`.
  - `tready` may be held high permanently.
- After STOP the block returns to IDLE at mid-stop-bit. A following start edge is detectable immediately, so back-to-back frames need no idle gap.

## Timing
- **Reset values**: `m_axis_tvalid=0`, `m_axis_tdata=0`, `busy=0`, `frame_error=0`, `overrun_error=0`. The state machine is in IDLE, the synchronizer holds 1, and the counters are 0.
- **Reset mid-frame**: the frame is abandoned. Any pending `tvalid` is cleared and its byte is lost.
- **Pin to detection**: a falling edge on the `rxd` pin is visible in `rxd_s` 2 cycles later. Call the detection cycle D.
- **busy**: rises at D+1.
- **Sample points**: start sample at D+4P, data bit i at D+4P+8P(i+1) for i=0..7, stop sample at D+4P+72P.
- **Output cycle**: at stop-sample S, the following all happen at S+1:
  - `m_axis_tvalid` rises;
  - `busy` falls;
  - `frame_error` or `overrun_error` pulses high for exactly that cycle.
- **Simultaneous events**: a stop sample coinciding with a `tvalid && tready` handshake loads the new byte, `tvalid` stays 1, and there is no overrun.
- **Prescale changes**: a change in `prescale` mid-frame has no effect until the next start detection.

## Test plan
- **Single byte**: rst 2 cycles, prescale=1, `tready=1`; drive 0xA5 in 8N1 at 8 clocks/bit.
  - Required: `tdata=0xA5`, `tvalid` high exactly 1 cycle, `busy` high for 4+72 cycles, no error pulses.
- **Back-to-back**: prescale=2, `tready=1`; send 0x00, 0xFF, 0x3C with no idle between frames.
  - Required: three handshakes in order 0x00, 0xFF, 0x3C.
- **Backpressure/overrun**: `tready=0`; send 0x3C then 0xC3.
  - Required: `tdata` holds 0x3C with `tvalid=1` throughout, and `overrun_error` pulses once at the 0xC3 stop sample.
  - Then raise `tready` for 1 cycle: only 0x3C is delivered and `tvalid` drops.
- **Framing**: send 0x55 with the stop bit driven 0.
  - Required: `frame_error` pulses 1 cycle, `tvalid` stays 0.
  - A following valid 0x12 is received correctly.
- **Glitch**: prescale=4; drive `rxd` low for 3 cycles, then high.
  - Required: `busy` pulses and clears after the start sample; no `tvalid`, no errors.
- **Reset mid-frame**: assert rst during bit 4 of 0x81, then send 0x7E.
  - Required: all outputs are at reset values the cycle after rst, and only 0x7E is delivered.
